// File: rtl/i2c_tmp_slave_core_if.sv
// I2C pad-side bundle for the TMP10X slave core.
// SDA is open-drain: the slave only ever pulls low through sda_oe.
interface i2c_tmp_slave_core_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport master (
    output scl_i,
    output sda_i,
    input  sda_oe
  );

  modport slave (
    input  scl_i,
    input  sda_i,
    output sda_oe
  );
endinterface

// File: rtl/i2c_tmp_slave_core.sv
// Oversampling I2C slave core for the TMP10X model: START/STOP detection,
// pin-strapped address match and pointer-register read/write protocol.
module i2c_tmp_slave_core #(
  parameter int ADDRESSLENGTH = 7,
  parameter logic [ADDRESSLENGTH-1:0] BASE_ADDR = 7'b1001000,
  parameter int NREGS = 4,
  parameter int NBYTES = 2,
  parameter logic [NREGS-1:0] RO_MASK = 4'b0001,
  parameter int SYNC_STAGES = 2,
  localparam int PW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  i2c_tmp_slave_core_if.slave   bus,
  input  logic                  add0,
  input  logic                  add1,
  output logic [PW-1:0]         ptr,
  input  logic [8*NBYTES-1:0]   rd_data,
  output logic                  wr_en,
  output logic [PW-1:0]         wr_ptr,
  output logic [8*NBYTES-1:0]   wr_data,
  output logic                  busy,
  output logic                  addr_hit
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int DW = 8 * NBYTES;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_MACK,
    S_IGNORE
  } state_e;

  logic [SS-1:0] scl_sy_q;
  logic [SS-1:0] sda_sy_q;
  logic          scl_prev_q;
  logic          sda_prev_q;
  logic          scl_s;
  logic          sda_s;
  logic          scl_rise;
  logic          scl_fall;
  logic          start_det;
  logic          stop_det;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sy_q   <= '1;
      sda_sy_q   <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sy_q   <= {scl_sy_q[SS-2:0], bus.scl_i};
      sda_sy_q   <= {sda_sy_q[SS-2:0], bus.sda_i};
      scl_prev_q <= scl_sy_q[SS-1];
      sda_prev_q <= sda_sy_q[SS-1];
    end
  end

  assign scl_s     = scl_sy_q[SS-1];
  assign sda_s     = sda_sy_q[SS-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [7:0]      sh_q, sh_d;
  logic            rw_q, rw_d;
  logic [IW-1:0]   bidx_q, bidx_d;
  logic [DW-1:0]   wbuf_q, wbuf_d;
  logic            mack_q, mack_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            wr_en_q, wr_en_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            busy_q, busy_d;
  logic            hit_q, hit_d;
  logic            sda_oe_q, sda_oe_d;

  logic [ADDRESSLENGTH-1:0] my_addr;
  logic [IW-1:0]            rd_sel;
  logic [7:0]               rd_byte;

  assign my_addr = {BASE_ADDR[ADDRESSLENGTH-1:2], add1, add0};
  assign rd_sel  = (state_q == S_ADDR_ACK) ? '0 : bidx_q;

  // Byte 0 is the most significant byte of the register
  always_comb begin
    rd_byte = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (rd_sel == IW'(k)) rd_byte = rd_data[8*(NBYTES-1-k) +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    rw_d      = rw_q;
    bidx_d    = bidx_q;
    wbuf_d    = wbuf_q;
    mack_d    = mack_q;
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    hit_d     = 1'b0;
    sda_oe_d  = sda_oe_q;

    if (start_det) begin
      state_d  = S_ADDR;
      cnt_d    = '0;
      busy_d   = 1'b1;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ADDR: begin
          if (scl_rise && cnt_q != 4'd8) begin
            sh_d  = {sh_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              rw_d = sda_s;
              if (sh_q[ADDRESSLENGTH-1:0] == my_addr) hit_d = 1'b1;
              else state_d = S_IGNORE;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            state_d  = S_ADDR_ACK;
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            if (rw_q) begin
              sh_d     = rd_byte;
              bidx_d   = '0;
              sda_oe_d = ~rd_byte[7];
              state_d  = S_RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_PTR;
            end
          end
        end
        S_PTR, S_WDATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            sh_d  = {sh_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            cnt_d    = '0;
            if (state_q == S_PTR) begin
              ptr_d   = sh_q[PW-1:0];
              state_d = S_PTR_ACK;
            end else begin
              for (int k = 0; k < NBYTES; k++) begin
                if (bidx_q == IW'(k)) wbuf_d[8*(NBYTES-1-k) +: 8] = sh_q;
              end
              if (bidx_q == IW'(NBYTES-1)) begin
                bidx_d = '0;
                if (!RO_MASK[ptr_q]) begin
                  wr_en_d   = 1'b1;
                  wr_ptr_d  = ptr_q;
                  wr_data_d = wbuf_d;
                end
              end else begin
                bidx_d = bidx_q + IW'(1);
              end
              state_d = S_WDATA_ACK;
            end
          end
        end
        S_PTR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            bidx_d   = '0;
            state_d  = S_WDATA;
          end
        end
        S_WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = S_WDATA;
          end
        end
        S_RDATA: begin
          if (scl_rise && cnt_q != 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              mack_d   = 1'b0;
              state_d  = S_RDATA_MACK;
            end else begin
              sh_d     = {sh_q[6:0], 1'b0};
              sda_oe_d = ~sh_q[6];
            end
          end
        end
        S_RDATA_MACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              sda_oe_d = 1'b0;
              state_d  = S_IGNORE;
            end else begin
              mack_d = 1'b1;
              if (bidx_q == IW'(NBYTES-1)) bidx_d = '0;
              else bidx_d = bidx_q + IW'(1);
            end
          end else if (scl_fall && mack_q) begin
            sh_d     = rd_byte;
            sda_oe_d = ~rd_byte[7];
            cnt_d    = '0;
            state_d  = S_RDATA;
          end
        end
        S_IGNORE: sda_oe_d = 1'b0;
        default: begin
          state_d  = S_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      rw_q      <= 1'b0;
      bidx_q    <= '0;
      wbuf_q    <= '0;
      mack_q    <= 1'b0;
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_ptr_q  <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      hit_q     <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      rw_q      <= rw_d;
      bidx_q    <= bidx_d;
      wbuf_q    <= wbuf_d;
      mack_q    <= mack_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_ptr_q  <= wr_ptr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      hit_q     <= hit_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign ptr        = ptr_q;
  assign wr_en      = wr_en_q;
  assign wr_ptr     = wr_ptr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign addr_hit   = hit_q;

endmodule

// File: tb/tb_i2c_tmp_slave_core.sv
// Directed bench for i2c_tmp_slave_core: bit-banged I2C master,
// small register-file model behind rd_data/wr_en.
module tb_i2c_tmp_slave_core;

  localparam int Q = 40;
  localparam int H = 80;

  logic        clk;
  logic        rst_n;
  logic        scl_m;
  logic        sda_m;
  logic        add0;
  logic        add1;
  logic [1:0]  ptr;
  logic [15:0] rd_data;
  logic        wr_en;
  logic [1:0]  wr_ptr;
  logic [15:0] wr_data;
  logic        busy;
  logic        addr_hit;

  i2c_tmp_slave_core_if bus();

  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;

  i2c_tmp_slave_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .add0     (add0),
    .add1     (add1),
    .ptr      (ptr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_ptr   (wr_ptr),
    .wr_data  (wr_data),
    .busy     (busy),
    .addr_hit (addr_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] regs [4];
  assign rd_data = regs[ptr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs[0] <= 16'h1A2B;
      regs[1] <= 16'h0000;
      regs[2] <= 16'hABCD;
      regs[3] <= 16'h0F0F;
    end else if (wr_en) begin
      regs[wr_ptr] <= wr_data;
    end
  end

  int          n_vec;
  int          n_err;
  int          n_wr;
  int          n_hit;
  int          n_glitch;
  logic [1:0]  last_wr_ptr;
  logic [15:0] last_wr_data;
  logic        oe_prev;

  initial begin
    n_wr = 0;
    n_hit = 0;
    n_glitch = 0;
    last_wr_ptr = '0;
    last_wr_data = '0;
    oe_prev = 1'b0;
  end

  always @(posedge clk) begin
    if (wr_en) begin
      n_wr++;
      last_wr_ptr = wr_ptr;
      last_wr_data = wr_data;
    end
    if (addr_hit) n_hit++;
    if (rst_n && scl_m && bus.sda_oe !== oe_prev) n_glitch++;
    oe_prev = bus.sda_oe;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    #Q;
    scl_m = 1'b1;
    #Q;
    sda_m = 1'b0;
    #Q;
    scl_m = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    #Q;
    scl_m = 1'b1;
    #Q;
    sda_m = 1'b1;
    #Q;
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i];
      #Q;
      scl_m = 1'b1;
      #H;
      scl_m = 1'b0;
      #Q;
    end
    sda_m = 1'b1;
    #Q;
    scl_m = 1'b1;
    #(H/2);
    ack = bus.sda_i;
    #(H/2);
    scl_m = 1'b0;
    #Q;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    d = '0;
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #Q;
      scl_m = 1'b1;
      #(H/2);
      d = {d[6:0], bus.sda_i};
      #(H/2);
      scl_m = 1'b0;
    end
    #Q;
    sda_m = mack;
    #Q;
    scl_m = 1'b1;
    #H;
    scl_m = 1'b0;
    #Q;
    sda_m = 1'b1;
  endtask

  logic       ack;
  logic [7:0] d;

  initial begin
    n_vec = 0;
    n_err = 0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    add1  = 1'b0;
    add0  = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    check("rst_sda_oe", 32'(bus.sda_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ptr", 32'(ptr), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_addr_hit", 32'(addr_hit), 0);

    // Address match, write direction
    i2c_start();
    check("t1_busy", 32'(busy), 1);
    wr_byte(8'h92, ack);
    check("t1_ack", 32'(ack), 0);
    check("t1_hits", 32'(n_hit), 1);
    i2c_stop();
    #Q;
    check("t1_busy_end", 32'(busy), 0);

    // Address mismatch
    i2c_start();
    wr_byte(8'h90, ack);
    check("t2_nack_addr", 32'(ack), 1);
    wr_byte(8'h55, ack);
    check("t2_nack_data", 32'(ack), 1);
    check("t2_hits", 32'(n_hit), 1);
    i2c_stop();
    check("t2_sda_oe", 32'(bus.sda_oe), 0);

    // Pointer write + data write to reg 1
    i2c_start();
    wr_byte(8'h92, ack);
    check("t3_ack_a", 32'(ack), 0);
    wr_byte(8'h01, ack);
    check("t3_ack_p", 32'(ack), 0);
    wr_byte(8'h12, ack);
    check("t3_ack_d0", 32'(ack), 0);
    wr_byte(8'h34, ack);
    check("t3_ack_d1", 32'(ack), 0);
    i2c_stop();
    #Q;
    check("t3_ptr", 32'(ptr), 1);
    check("t3_nwr", 32'(n_wr), 1);
    check("t3_wr_ptr", 32'(last_wr_ptr), 1);
    check("t3_wr_data", 32'(last_wr_data), 32'h1234);

    // Read-only register 0
    i2c_start();
    wr_byte(8'h92, ack);
    check("t4_ack_a", 32'(ack), 0);
    wr_byte(8'h00, ack);
    check("t4_ack_p", 32'(ack), 0);
    wr_byte(8'h56, ack);
    check("t4_ack_d0", 32'(ack), 0);
    wr_byte(8'h78, ack);
    check("t4_ack_d1", 32'(ack), 0);
    i2c_stop();
    #Q;
    check("t4_nwr", 32'(n_wr), 1);
    check("t4_ptr", 32'(ptr), 0);

    // Pointer 2, repeated START, read with wrap
    i2c_start();
    wr_byte(8'h92, ack);
    check("t5_ack_a", 32'(ack), 0);
    wr_byte(8'h02, ack);
    check("t5_ack_p", 32'(ack), 0);
    i2c_start();
    wr_byte(8'h93, ack);
    check("t5_ack_r", 32'(ack), 0);
    rd_byte(1'b0, d);
    check("t5_byte0", 32'(d), 32'hAB);
    rd_byte(1'b0, d);
    check("t5_byte1", 32'(d), 32'hCD);
    rd_byte(1'b1, d);
    check("t5_byte2", 32'(d), 32'hAB);
    check("t5_sda_rel", 32'(bus.sda_oe), 0);
    i2c_stop();
    check("t5_ptr", 32'(ptr), 2);
    check("t5_nwr", 32'(n_wr), 1);

    // Partial register write discarded
    i2c_start();
    wr_byte(8'h92, ack);
    wr_byte(8'h03, ack);
    wr_byte(8'h11, ack);
    check("t6_ack_d0", 32'(ack), 0);
    i2c_stop();
    #Q;
    check("t6_nwr", 32'(n_wr), 1);
    check("t6_ptr", 32'(ptr), 3);

    // Pointer persists into a separate read transaction
    i2c_start();
    wr_byte(8'h92, ack);
    wr_byte(8'h01, ack);
    check("t8_ack_p", 32'(ack), 0);
    i2c_stop();
    #Q;
    i2c_start();
    wr_byte(8'h93, ack);
    check("t8_ack_r", 32'(ack), 0);
    rd_byte(1'b0, d);
    check("t8_byte0", 32'(d), 32'h12);
    rd_byte(1'b1, d);
    check("t8_byte1", 32'(d), 32'h34);
    i2c_stop();
    #Q;

    // Reset mid-read of reg 3 (MSB byte 0x0F drives bit7 low)
    i2c_start();
    wr_byte(8'h92, ack);
    wr_byte(8'h03, ack);
    i2c_stop();
    #Q;
    i2c_start();
    wr_byte(8'h93, ack);
    check("t7_drive", 32'(bus.sda_oe), 1);
    check("t7_busy_pre", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t7_sda_oe", 32'(bus.sda_oe), 0);
    check("t7_busy", 32'(busy), 0);
    check("t7_ptr", 32'(ptr), 0);
    sda_m = 1'b1;
    #Q;
    scl_m = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("t7_nwr", 32'(n_wr), 1);
    check("oe_scl_high", 32'(n_glitch), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
